// File: rtl/traffic_light_ctrl.sv
// Intersection phase controller: animation-tick prescaler plus a 4-phase traffic light FSM.
// Optional vehicle-sensor early exit from green is enabled by defining TL_SENSOR_EN.
module traffic_light_ctrl #(
  parameter int ANIM_DIV    = 250000,
  parameter int GREEN_TICKS = 300,
  parameter int CLEAR_TICKS = 100,
  parameter int GREEN_MIN   = 100
) (
  input  logic       i_dclk,
  input  logic       i_clr_n,
  input  logic       i_run,
`ifdef TL_SENSOR_EN
  input  logic       i_req_ew,
  input  logic       i_req_ns,
`endif
  output logic       o_anim_clk,
  output logic       o_traffic0_color,
  output logic       o_traffic1_color,
  output logic       o_traffic2_color,
  output logic       o_traffic3_color,
  output logic [1:0] o_phase
);

  typedef enum logic [1:0] {
    EW_GO    = 2'd0,
    EW_CLEAR = 2'd1,
    NS_GO    = 2'd2,
    NS_CLEAR = 2'd3
  } phase_t;

  localparam int              PW         = $clog2(ANIM_DIV);
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(ANIM_DIV - 1);
  localparam logic [15:0]     GREEN_LAST = 16'(GREEN_TICKS - 1);
  localparam logic [15:0]     CLEAR_LAST = 16'(CLEAR_TICKS - 1);

  if (ANIM_DIV < 2 || GREEN_MIN > GREEN_TICKS || GREEN_TICKS < 1 || CLEAR_TICKS < 1) begin : g_bad_params
    $error("traffic_light_ctrl: illegal parameter combination");
  end

  logic [PW-1:0] r_presc;
  logic [15:0]   r_phase_cnt;
  phase_t        r_phase;
  logic          r_anim_clk;
  logic [3:0]    r_color;

  logic          w_tick;
  logic          w_early_exit;
  logic [15:0]   w_last;
  logic [15:0]   w_next_cnt;
  phase_t        w_next_phase;
  logic [3:0]    w_next_color;

  assign w_tick = i_run && (r_presc == PRESC_MAX);

`ifdef TL_SENSOR_EN
  localparam logic [15:0] EARLY_MIN = 16'((GREEN_MIN > 0) ? GREEN_MIN - 1 : 0);

  logic [1:0] r_req_ew_sync;
  logic [1:0] r_req_ns_sync;

  always_ff @(posedge i_dclk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_req_ew_sync <= '0;
      r_req_ns_sync <= '0;
    end else begin
      r_req_ew_sync <= {r_req_ew_sync[0], i_req_ew};
      r_req_ns_sync <= {r_req_ns_sync[0], i_req_ns};
    end
  end

  // Green may end early once its minimum has elapsed and only the crossing road is waiting.
  always_comb begin
    w_early_exit = 1'b0;
    case (r_phase)
      EW_GO:   w_early_exit = (r_phase_cnt >= EARLY_MIN) && r_req_ns_sync[1] && !r_req_ew_sync[1];
      NS_GO:   w_early_exit = (r_phase_cnt >= EARLY_MIN) && r_req_ew_sync[1] && !r_req_ns_sync[1];
      default: w_early_exit = 1'b0;
    endcase
  end
`else
  assign w_early_exit = 1'b0;
`endif

  always_comb begin
    w_next_phase = r_phase;
    w_next_cnt   = r_phase_cnt;
    w_next_color = 4'b0000;
    w_last       = ((r_phase == EW_GO) || (r_phase == NS_GO)) ? GREEN_LAST : CLEAR_LAST;

    if (w_tick) begin
      if ((r_phase_cnt == w_last) || w_early_exit) begin
        w_next_cnt = 16'd0;
        case (r_phase)
          EW_GO:    w_next_phase = EW_CLEAR;
          EW_CLEAR: w_next_phase = NS_GO;
          NS_GO:    w_next_phase = NS_CLEAR;
          default:  w_next_phase = EW_GO;
        endcase
      end else begin
        w_next_cnt = r_phase_cnt + 16'd1;
      end
    end

    // Colours follow the upcoming phase so they switch on the same edge as o_phase.
    case (w_next_phase)
      EW_GO:   w_next_color = 4'b0011;
      NS_GO:   w_next_color = 4'b1100;
      default: w_next_color = 4'b0000;
    endcase
  end

  always_ff @(posedge i_dclk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_presc     <= '0;
      r_anim_clk  <= 1'b0;
      r_phase_cnt <= 16'd0;
      r_phase     <= NS_CLEAR;
      r_color     <= 4'b0000;
    end else begin
      r_anim_clk <= w_tick;
      if (i_run) begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
      end
      r_phase_cnt <= w_next_cnt;
      r_phase     <= w_next_phase;
      r_color     <= w_next_color;
    end
  end

  assign o_anim_clk       = r_anim_clk;
  assign o_phase          = r_phase;
  assign o_traffic0_color = r_color[0];
  assign o_traffic1_color = r_color[1];
  assign o_traffic2_color = r_color[2];
  assign o_traffic3_color = r_color[3];

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: a tick-count reference model is compared every cycle,
// with hand-computed literal checkpoints for reset, freeze, mid-phase reset and random run toggling.
module tb_traffic_light_ctrl;

  localparam int DIV    = 4;
  localparam int GT     = 3;
  localparam int CT     = 2;
  localparam int GM     = 1;
  localparam int PERIOD = 2 * (GT + CT);

  logic       clk  = 1'b0;
  logic       clrN = 1'b0;
  logic       run  = 1'b0;
  logic       animClk;
  logic       t0, t1, t2, t3;
  logic [1:0] phase;

  int   compared   = 0;
  int   mismatched = 0;
  int   runCycles  = 0;
  logic animExp    = 1'b0;
  logic prevAnim   = 1'b0;
  bit   checking   = 1'b0;

  always #5 clk = ~clk;

  traffic_light_ctrl #(
    .ANIM_DIV   (DIV),
    .GREEN_TICKS(GT),
    .CLEAR_TICKS(CT),
    .GREEN_MIN  (GM)
  ) dut (
    .i_dclk          (clk),
    .i_clr_n         (clrN),
    .i_run           (run),
`ifdef TL_SENSOR_EN
    .i_req_ew        (1'b0),
    .i_req_ns        (1'b0),
`endif
    .o_anim_clk      (animClk),
    .o_traffic0_color(t0),
    .o_traffic1_color(t1),
    .o_traffic2_color(t2),
    .o_traffic3_color(t3),
    .o_phase         (phase)
  );

  // Phase as a function of total ticks since reset: one NS_CLEAR lead-in, then a fixed 10-tick cycle.
  function automatic int phaseOfTicks(input int ticks);
    int t;
    if (ticks < CT) return 3;
    t = (ticks - CT) % PERIOD;
    if (t < GT)          return 0;
    if (t < GT + CT)     return 1;
    if (t < 2 * GT + CT) return 2;
    return 3;
  endfunction

  function automatic int colorsOf(input int ph);
    if (ph == 0) return 4'b0011;
    if (ph == 2) return 4'b1100;
    return 0;
  endfunction

  // The reference only counts run-enabled edges; every output is derived from that count.
  always @(posedge clk or negedge clrN) begin
    if (!clrN) begin
      runCycles = 0;
      animExp   = 1'b0;
    end else if (run) begin
      runCycles = runCycles + 1;
      animExp   = ((runCycles % DIV) == 0);
    end else begin
      animExp = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared = compared + 1;
    if (actual != expected) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic runVal, input int cycles);
    run = runVal;
    repeat (cycles) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("anim_clk", int'(animClk), int'(animExp));
      checkOutput("phase", int'(phase), phaseOfTicks(runCycles / DIV));
      checkOutput("colors", int'({t3, t2, t1, t0}), colorsOf(phaseOfTicks(runCycles / DIV)));
      checkOutput("ew_ns_exclusive", int'((t0 | t1) & (t2 | t3)), 0);
      checkOutput("anim_double_pulse", int'(prevAnim & animClk), 0);
      prevAnim = animClk;
    end
  end

  initial begin
    clrN = 1'b0;
    run  = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_phase", int'(phase), 3);
    checkOutput("reset_colors", int'({t3, t2, t1, t0}), 0);
    checkOutput("reset_anim", int'(animClk), 0);
    clrN     = 1'b1;
    checking = 1'b1;

    for (int k = 1; k <= 48; k++) begin
      applyStimulus(1'b1, 1);
      case (k)
        3:  checkOutput("lit_anim_k3", int'(animClk), 0);
        4:  checkOutput("lit_anim_k4", int'(animClk), 1);
        5:  checkOutput("lit_anim_k5", int'(animClk), 0);
        7:  checkOutput("lit_phase_k7", int'(phase), 3);
        8:  checkOutput("lit_colors_k8", int'({t3, t2, t1, t0}), 4'b0011);
        19: checkOutput("lit_phase_k19", int'(phase), 0);
        20: checkOutput("lit_phase_k20", int'(phase), 1);
        28: checkOutput("lit_colors_k28", int'({t3, t2, t1, t0}), 4'b1100);
        40: checkOutput("lit_phase_k40", int'(phase), 3);
        48: checkOutput("lit_phase_k48", int'(phase), 0);
        default: ;
      endcase
    end

    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 50);
    checkOutput("freeze_phase", int'(phase), 0);
    checkOutput("freeze_colors", int'({t3, t2, t1, t0}), 4'b0011);
    applyStimulus(1'b1, 9);
    checkOutput("resume_phase_before", int'(phase), 0);
    applyStimulus(1'b1, 1);
    checkOutput("resume_phase_after", int'(phase), 1);

    applyStimulus(1'b1, 12);
    checkOutput("ns_go_phase", int'(phase), 2);
    @(posedge clk);
    #2 clrN = 1'b0;
    #1;
    checkOutput("async_clr_phase", int'(phase), 3);
    checkOutput("async_clr_colors", int'({t3, t2, t1, t0}), 0);
    checkOutput("async_clr_anim", int'(animClk), 0);
    @(negedge clk);
    clrN = 1'b1;
    applyStimulus(1'b1, 7);
    checkOutput("post_clr_red", int'(phase), 3);
    applyStimulus(1'b1, 1);
    checkOutput("post_clr_ew_go", int'(phase), 0);
    checkOutput("post_clr_colors", int'({t3, t2, t1, t0}), 4'b0011);

    for (int i = 0; i < 10000; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 1);
    end

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
